lsu_riscv: RTL

Load-store unit that services the memory requests produced by the RISC-V instruction decoder: mem_req, mem_we, mem_size and the ALU-computed address.
- Drives a word-organised data memory with byte enables and a variable-latency ready handshake.
- Aligns and sign- or zero-extends read data.
- Returns lsu_stall_req to the decoder/PC logic, holding the core until the access completes.

---
 rtl/lsu_riscv_if.sv | 22 ++
 rtl/lsu_riscv.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lsu_riscv_if.sv
// Data-memory bus between lsu_riscv (master) and a word-organised memory (slave).
interface lsu_riscv_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wd,
    input  mem_rd, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wd,
    output mem_rd, mem_ready
  );
endinterface

// File: rtl/lsu_riscv.sv
// RISC-V load-store unit: captures a decoder request, drives a word memory with
// byte enables over a variable-latency ready handshake, and returns aligned,
// sign/zero-extended load data. Stalls the core until the access completes.
// Optional: define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses
// (no memory request, core_misalign_o pulses in the DONE cycle).
module lsu_riscv #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_misalign_o,
  lsu_riscv_if.master       mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;
  logic              req_misalign;

  // Size classes from funct3: low bits 00 = byte, 01 = half, anything else = word
  logic        is_byte, is_half, is_signed;
  logic [1:0]  lane;
  logic [31:0] byte_sh, half_sh, load_ext;
  logic [3:0]  be;
  logic [31:0] wd_rep;

  assign is_byte   = (size_q[1:0] == 2'b00);
  assign is_half   = (size_q[1:0] == 2'b01);
  assign is_signed = ~size_q[2];
  assign lane      = addr_q[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q;

  assign req_misalign = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                        ((core_size_i[1:0] == 2'b10 || core_size_i[1:0] == 2'b11) &&
                         (core_addr_i[1:0] != 2'b00));

  // Remember whether the accepted request was trapped as misaligned
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      misalign_q <= 1'b0;
    else if (state_q == IDLE && core_req_i)
      misalign_q <= req_misalign;
  end

  assign core_misalign_o = (state_q == DONE) && misalign_q;
`else
  assign req_misalign    = 1'b0;
  assign core_misalign_o = 1'b0;
`endif

  // Lane steering for byte enables, store replication and load extraction
  always_comb begin
    byte_sh = mem.mem_rd >> {lane, 3'b000};
    half_sh = mem.mem_rd >> {lane[1], 4'b0000};
    if (is_byte) begin
      be       = 4'b0001 << lane;
      wd_rep   = {4{wd_q[7:0]}};
      load_ext = {{24{is_signed & byte_sh[7]}}, byte_sh[7:0]};
    end else if (is_half) begin
      be       = 4'b0011 << {lane[1], 1'b0};
      wd_rep   = {2{wd_q[15:0]}};
      load_ext = {{16{is_signed & half_sh[15]}}, half_sh[15:0]};
    end else begin
      be       = 4'b1111;
      wd_rep   = wd_q;
      load_ext = mem.mem_rd;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (core_req_i) state_d = req_misalign ? DONE : BUSY;
      BUSY: if (mem.mem_ready) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture in IDLE, load data capture on the completing BUSY cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      size_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      if (state_q == IDLE && core_req_i) begin
        addr_q <= core_addr_i;
        we_q   <= core_we_i;
        size_q <= core_size_i;
        wd_q   <= core_wd_i;
      end
      if (state_q == BUSY && mem.mem_ready && !we_q)
        rd_q <= load_ext;
    end
  end

  // Outputs: memory bus only active in BUSY, stall mirrors request in IDLE
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_be   = '0;
    mem.mem_addr = '0;
    mem.mem_wd   = '0;
    core_stall_o = 1'b0;
    unique case (state_q)
      IDLE: core_stall_o = core_req_i;
      BUSY: begin
        core_stall_o = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_we   = we_q;
        mem.mem_be   = be;
        mem.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        mem.mem_wd   = wd_rep;
      end
      default: core_stall_o = 1'b0;
    endcase
  end

  assign core_rd_o = rd_q;

endmodule
